bus_protocol_arbiter: RTL and testbench



---
 rtl/bus_protocol_arbiter_if.sv | 29 ++
 rtl/bus_protocol_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_protocol_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_protocol_arbiter_if.sv
// Bundle of the requester side and the dValid/dAck/data bus seen by the arbiter.
// Bus handshake: the master raises dValid with a stable byte on data. The target
// answers with dAck, and dValid drops on the clock after dAck is sampled.
interface bus_protocol_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 dValid;
  logic [7:0]           data;
  logic                 dAck;
  logic                 busy;
  logic                 xfer_done;
  logic [ID_W-1:0]      xfer_id;
  logic [1:0]           xfer_status;
  logic [0:0]           state_dbg;

  modport master (
    input  req, req_data, dAck,
    output gnt, dValid, data, busy, xfer_done, xfer_id, xfer_status, state_dbg
  );

  modport slave (
    output req, req_data, dAck,
    input  gnt, dValid, data, busy, xfer_done, xfer_id, xfer_status, state_dbg
  );
endinterface

// File: rtl/bus_protocol_arbiter.sv
// Round-robin master sequencer for the 8-bit dValid/dAck bus: grants one requester,
// holds its byte on the bus for 1..5 cycles and reports ok / early ack / timeout.
module bus_protocol_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_protocol_arbiter_if.master bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_EARLY   = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  logic [0:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic               dvalid_q, dvalid_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [1:0]         status_q, status_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  int                 idx;

  // Search starts just after the previous winner, so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    dvalid_d = dvalid_q;
    data_d   = data_q;
    gnt_d    = '0;
    done_d   = 1'b0;
    id_d     = id_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: begin
        dvalid_d = 1'b0;
        data_d   = 8'h00;
        if (found) begin
          state_d  = ST_XFER;
          dvalid_d = 1'b1;
          data_d   = bus.req_data[{winner, 3'b000} +: 8];
          gnt_d    = NUM_REQ'(1) << winner;
          last_d   = winner;
          cnt_d    = 3'd0;
        end
      end
      ST_XFER: begin
        // cnt is the index of the dValid cycle being sampled; 4 is the last allowed one.
        if (bus.dAck || cnt_q == 3'd4) begin
          state_d  = ST_IDLE;
          dvalid_d = 1'b0;
          data_d   = 8'h00;
          done_d   = 1'b1;
          id_d     = last_q;
          if (!bus.dAck)
            status_d = STAT_TIMEOUT;
          else if (cnt_q < 3'd2)
            status_d = STAT_EARLY;
          else
            status_d = STAT_OK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      last_q   <= ID_W'(NUM_REQ - 1);
      dvalid_q <= 1'b0;
      data_q   <= 8'h00;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      id_q     <= '0;
      status_q <= STAT_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      dvalid_q <= dvalid_d;
      data_q   <= data_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      id_q     <= id_d;
      status_q <= status_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.dValid      = dvalid_q;
  assign bus.data        = data_q;
  assign bus.busy        = dvalid_q;
  assign bus.xfer_done   = done_q;
  assign bus.xfer_id     = id_q;
  assign bus.xfer_status = status_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Directed and random transfers on bus_protocol_arbiter, checked against an expected queue.
module tb_bus_protocol_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 2 + 8;

  logic clk;
  logic reset;

  bus_protocol_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  bus_protocol_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]    exp_q[$];
  logic [ID_W-1:0] model_last;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] w;
    bit found;
    int i;
    w = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (int'(last) + k) % NUM_REQ;
      if (!found && rq[i]) begin
        found = 1'b1;
        w = ID_W'(i);
      end
    end
    return w;
  endfunction

  // ---------------- driver ----------------
  // Requests with rq, acks at dValid index ack_at (-1 = never) and follows the
  // transfer to its completion cycle. Returns in the xfer_done cycle.
  task automatic run_xfer(input logic [NUM_REQ-1:0] rq, input bit hold, input int ack_at,
                          input logic [ID_W-1:0] exp_id, input logic [1:0] exp_status);
    logic [7:0] exp_data;
    logic [7:0] seen_data;
    logic [W-1:0] exp_word;
    int waits;
    int c;
    bit ended;
    exp_data = bus.req_data[int'(exp_id) * 8 +: 8];
    exp_q.push_back({exp_id, exp_status, exp_data});
    bus.req = rq;
    waits = 0;
    while (bus.gnt == '0 && waits < 20) begin
      tick();
      waits++;
    end
    check("gnt_latency", waits, 1);
    if (bus.gnt == '0) return;
    check("gnt_onehot", {28'd0, bus.gnt}, 32'd1 << exp_id);
    check("done_cleared", {31'd0, bus.xfer_done}, 0);
    if (!hold) bus.req = '0;
    seen_data = bus.data;
    ended = 1'b0;
    c = 0;
    while (!ended) begin
      check("dvalid_high", {31'd0, bus.dValid}, 1);
      check("busy_high", {31'd0, bus.busy}, 1);
      check("data_stable", {24'd0, bus.data}, {24'd0, exp_data});
      if (c > 0) check("gnt_pulse", {28'd0, bus.gnt}, 0);
      bus.dAck = (c == ack_at);
      tick();
      bus.dAck = 1'b0;
      if (c == ack_at || c == 4) ended = 1'b1;
      else c++;
    end
    check("dvalid_low", {31'd0, bus.dValid}, 0);
    check("data_zero", {24'd0, bus.data}, 0);
    check("busy_low", {31'd0, bus.busy}, 0);
    check("done_pulse", {31'd0, bus.xfer_done}, 1);
    // ---------------- scoreboard ----------------
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      exp_word = exp_q.pop_front();
      check("sb_id_status_data", {20'd0, bus.xfer_id, bus.xfer_status, seen_data},
            {20'd0, exp_word});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_REQ-1:0] rq;
    logic [ID_W-1:0] w;
    logic [1:0] st;
    int ack;

    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.dAck = 1'b0;
    repeat (3) tick();
    check("rst_dvalid", {31'd0, bus.dValid}, 0);
    check("rst_data", {24'd0, bus.data}, 0);
    check("rst_gnt", {28'd0, bus.gnt}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.xfer_done}, 0);
    check("rst_id", {30'd0, bus.xfer_id}, 0);
    check("rst_status", {30'd0, bus.xfer_status}, 0);
    reset = 1'b0;
    tick();

    // dAck while idle must not start or finish anything
    bus.dAck = 1'b1;
    tick();
    tick();
    check("idle_ack_dvalid", {31'd0, bus.dValid}, 0);
    check("idle_ack_done", {31'd0, bus.xfer_done}, 0);
    bus.dAck = 1'b0;

    // ack at T+2, ack at T+4, timeout, early acks
    bus.req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    run_xfer(4'b0100, 1'b0, 2, 2'd2, 2'b00);
    run_xfer(4'b0010, 1'b0, 4, 2'd1, 2'b00);
    run_xfer(4'b1000, 1'b0, -1, 2'd3, 2'b10);
    run_xfer(4'b0001, 1'b0, 1, 2'd0, 2'b01);
    run_xfer(4'b0100, 1'b0, 0, 2'd2, 2'b01);

    // round-robin with all requesters held from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sb_empty_rr", exp_q.size(), 0);
    bus.req_data = {$urandom};
    run_xfer(4'b1111, 1'b1, 2, 2'd0, 2'b00);
    run_xfer(4'b1111, 1'b1, 2, 2'd1, 2'b00);
    run_xfer(4'b1111, 1'b1, 2, 2'd2, 2'b00);
    run_xfer(4'b1111, 1'b1, 2, 2'd3, 2'b00);
    run_xfer(4'b1111, 1'b1, 2, 2'd0, 2'b00);
    run_xfer(4'b1001, 1'b0, 2, 2'd3, 2'b00);

    // reset in the middle of a transfer granted to requester 0
    bus.req_data = {$urandom};
    bus.req = 4'b0001;
    tick();
    check("abort_gnt", {28'd0, bus.gnt}, 1);
    bus.req = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_dvalid", {31'd0, bus.dValid}, 0);
    check("abort_data", {24'd0, bus.data}, 0);
    check("abort_no_done", {31'd0, bus.xfer_done}, 0);
    tick();
    check("abort_no_done_late", {31'd0, bus.xfer_done}, 0);
    check("abort_stays_idle", {31'd0, bus.dValid}, 0);
    run_xfer(4'b0011, 1'b0, 2, 2'd0, 2'b00);
    model_last = 2'd0;

    // random requests and ack timing
    for (int i = 0; i < 12; i++) begin
      rq = NUM_REQ'($urandom_range(1, 15));
      bus.req_data = {$urandom};
      w = rr_pick(rq, model_last);
      ack = int'($urandom_range(0, 5));
      if (ack == 5) ack = -1;
      st = (ack < 0) ? 2'b10 : (ack < 2) ? 2'b01 : 2'b00;
      run_xfer(rq, 1'b0, ack, w, st);
      model_last = w;
    end

    tick();
    check("final_done_cleared", {31'd0, bus.xfer_done}, 0);
    check("sb_empty_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
